// File: rtl/aes_sub_bytes_if.sv
// State bus for the SubBytes stage: the driver of `in` uses master,
// and the substitution stage uses slave.
interface aes_sub_bytes_if;
    logic [127:0] in;
    logic [127:0] out;

    modport master (output in, input out);
    modport slave (input in, output out);
endinterface

// File: rtl/aes_sub_bytes.sv
// AES SubBytes: forward S-box applied to all 16 state bytes, one registered stage.
// Lane k reads and writes bits [127-8k -: 8]; lanes are never permuted.
module aes_sub_bytes (
    input  logic            clk,
    input  logic            rst,
    aes_sub_bytes_if.slave  bus
);

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    logic [127:0] sub_d;
    logic [127:0] out_q;

    always_comb begin
        sub_d = '0;
        for (int k = 0; k < 16; k++) begin
            sub_d[127 - 8 * k -: 8] = sbox(bus.in[127 - 8 * k -: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= sub_d;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_aes_sub_bytes.sv
// Scoreboard bench for aes_sub_bytes: the driver queues expected states at each
// negedge, and the monitor checks the registered output just after every posedge.
module tb_aes_sub_bytes;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_sub_bytes_if bus ();

    aes_sub_bytes dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [127:0] exp_q[$];
    string        name_q[$];
    logic [127:0] last_exp;
    logic [127:0] mon_exp;
    string        mon_name;
    int           checks = 0;
    int           fails = 0;

    // Independent S-box model: GF(2^8) inverse followed by the affine transform.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = '0;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] b);
        logic [7:0] inv = '0;
        if (b != 8'h00) begin
            for (int x = 1; x < 256; x++) begin
                if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
            end
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        logic [127:0] r = '0;
        for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = ref_sbox(s[127 - 8 * k -: 8]);
        return r;
    endfunction

    task automatic drive(input logic r, input logic [127:0] v, input logic [127:0] e,
                         input string nm);
        @(negedge clk);
        rst    = r;
        bus.in = v;
        exp_q.push_back(e);
        name_q.push_back(nm);
        last_exp = e;
    endtask

    // Wiggle `in` mid-cycle: out must hold, and only the final value is captured.
    task automatic drive_glitch(input logic [127:0] junk, input logic [127:0] v,
                                input logic [127:0] e, input string nm);
        @(negedge clk);
        rst    = 1'b0;
        bus.in = junk;
        #1;
        checks++;
        if (bus.out !== last_exp) begin
            fails++;
            $display("FAIL %s_hold: out=%h expected=%h", nm, bus.out, last_exp);
        end
        #2;
        bus.in = v;
        exp_q.push_back(e);
        name_q.push_back(nm);
        last_exp = e;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            checks++;
            if (bus.out !== mon_exp) begin
                fails++;
                $display("FAIL %s: out=%h expected=%h", mon_name, bus.out, mon_exp);
            end
        end
    end

    initial begin
        logic [127:0] v;
        rst    = 1'b1;
        bus.in = '0;

        drive(1'b1, 128'hdeadbeef_01234567_89abcdef_feedface, '0, "reset");
        drive(1'b0, 128'h00102030405060708090a0b0c0d0e0f0,
              128'h63cab7040953d051cd60e0e7ba70e18c, "after_reset_ramp");
        drive(1'b0, '0, {16{8'h63}}, "all_zero");
        drive(1'b0, {16{8'hff}}, {16{8'h16}}, "all_ff");
        drive(1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
              128'hd42711aee0bf98f1b8b45de51e415230, "fips_round1");
        drive(1'b0, 128'h00011053_80f0ff00_01105380_f0ff0001,
              128'h637ccaed_cd8c1663_7ccaedcd_8c16637c, "anchors");

        for (int b = 0; b < 256; b++) begin
            v = {16{8'(b)}};
            drive(1'b0, v, ref_state(v), $sformatf("exhaustive_%02x", b));
        end

        // Reset in the middle of a changing stream.
        drive(1'b0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
              ref_state(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0), "pre_reset");
        drive(1'b1, 128'h1122334455667788_99aabbccddeeff00, '0, "mid_reset");
        drive(1'b0, 128'h00112233445566778899aabbccddeeff,
              128'h638293c31bfc33f5c4eeacea4bc12816, "post_reset");
        drive_glitch(128'hffffffffffffffffffffffffffffffff, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                     128'hd42711aee0bf98f1b8b45de51e415230, "glitch");
        drive(1'b0, 128'h00102030405060708090a0b0c0d0e0f0,
              128'h63cab7040953d051cd60e0e7ba70e18c, "tail");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
